scnn_output_compressor: RTL and testbench

- Output-side stage of the SCNN PE; the encoder for the controller's dense output path.
- Accepts one frame of NUM_OUT dense 32-bit accumulator outputs from scnn_controller.
- Applies ReLU, a right shift and saturation to ACT_W bits.
- Emits only the nonzero activations as a compressed (value, index) stream, one beat per cycle, ready for the next layer's sparse input buffer.

---
 rtl/scnn_output_compressor.sv | 138 +++++++++++++
 tb/tb_scnn_output_compressor.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scnn_output_compressor.sv
// scnn_output_compressor: ReLU/shift/saturate a dense accumulator frame
// and stream out only the nonzero activations as (value, index) beats.
module scnn_output_compressor #(
  parameter int NUM_OUT    = 16,
  parameter int ACC_W      = 32,
  parameter int ACT_W      = 16,
  parameter int IDX_W      = 4,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OUT*ACC_W-1:0] in_outputs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACT_W-1:0]         out_value,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     out_empty,
  output logic [IDX_W:0]           nnz_count,
  output logic                     busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] MAXV =
    {{(ACC_W-ACT_W+1){1'b0}}, {(ACT_W-1){1'b1}}};

  state_t state_q, state_d;

  logic [NUM_OUT-1:0] mask_q;
  logic [ACT_W-1:0]   vbuf_q [NUM_OUT];
  logic [IDX_W:0]     nnz_q;
  logic               empty_q;

  logic [ACT_W-1:0]   xv [NUM_OUT];
  logic [NUM_OUT-1:0] xmask;
  logic [IDX_W:0]     xcnt;

  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_OUT-1:0] sel_oh;
  logic               one_left;
  logic               capture;
  logic               fire;

  // ReLU, arithmetic shift (input is nonnegative here) and clamp
  function automatic logic [ACT_W-1:0] xform(
    input logic [ACC_W-1:0] acc
  );
    logic [ACC_W-1:0] s;
    s = acc >> FRAC_SHIFT;
    if (acc[ACC_W-1]) return '0;
    if (s > MAXV) return MAXV[ACT_W-1:0];
    return s[ACT_W-1:0];
  endfunction

  // transform every element of the incoming frame and count nonzeros
  always_comb begin
    xcnt = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      xv[k]    = xform(in_outputs[k*ACC_W +: ACC_W]);
      xmask[k] = |xv[k];
      xcnt     = xcnt + (IDX_W+1)'(xmask[k]);
    end
  end

  // lowest remaining mask bit selects the next beat
  always_comb begin
    sel_idx = '0;
    for (int k = NUM_OUT - 1; k >= 0; k--) begin
      if (mask_q[k]) sel_idx = IDX_W'(k);
    end
    sel_oh   = NUM_OUT'(1) << sel_idx;
    one_left = (mask_q != '0) && ((mask_q & (mask_q - 1'b1)) == '0);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_empty = 1'b0;
    out_value = '0;
    out_index = '0;
    capture   = 1'b0;
    fire      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        capture  = in_valid;
        if (in_valid) state_d = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_empty = empty_q;
        out_last  = empty_q | one_left;
        out_value = vbuf_q[sel_idx];
        out_index = sel_idx;
        fire      = out_ready;
        if (out_ready && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // frame buffer, remaining mask and nonzero count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '0;
      nnz_q   <= '0;
      empty_q <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) vbuf_q[k] <= '0;
    end else if (capture) begin
      mask_q  <= xmask;
      nnz_q   <= xcnt;
      empty_q <= (xmask == '0);
      for (int k = 0; k < NUM_OUT; k++) vbuf_q[k] <= xv[k];
    end else if (fire) begin
      mask_q  <= mask_q & ~sel_oh;
    end
  end

  assign nnz_count = nnz_q;

endmodule

// File: tb/tb_scnn_output_compressor.sv
// tb_scnn_output_compressor: directed vectors for the output compressor,
// default instance plus a FRAC_SHIFT=2 instance.
module tb_scnn_output_compressor;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         out_ready = 0;

  logic         a_in_valid = 0;
  logic         a_in_ready;
  logic [511:0] a_in = '0;
  logic         a_valid, a_last, a_empty, a_busy;
  logic [15:0]  a_value;
  logic [3:0]   a_index;
  logic [4:0]   a_nnz;

  logic         b_in_valid = 0;
  logic         b_in_ready;
  logic [511:0] b_in = '0;
  logic         b_valid, b_last, b_empty, b_busy;
  logic [15:0]  b_value;
  logic [3:0]   b_index;
  logic [4:0]   b_nnz;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] cv [0:39];
  logic [3:0]  ci [0:39];
  logic        cl [0:39];
  logic        ce [0:39];
  int          cn;
  int          bub;
  bit          cto;

  always #5 clk = ~clk;

  scnn_output_compressor dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_outputs(a_in),
    .out_valid(a_valid), .out_ready(out_ready),
    .out_value(a_value), .out_index(a_index),
    .out_last(a_last), .out_empty(a_empty),
    .nnz_count(a_nnz), .busy(a_busy)
  );

  scnn_output_compressor #(.FRAC_SHIFT(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_outputs(b_in),
    .out_valid(b_valid), .out_ready(out_ready),
    .out_value(b_value), .out_index(b_index),
    .out_last(b_last), .out_empty(b_empty),
    .nnz_count(b_nnz), .busy(b_busy)
  );

  task automatic load(input bit sel, input logic [511:0] f);
    @(posedge clk); #1;
    if (sel) begin b_in_valid = 1; b_in = f; end
    else     begin a_in_valid = 1; a_in = f; end
    @(posedge clk); #1;
    a_in_valid = 0;
    b_in_valid = 0;
  endtask

  // gather beats until the last handshake; samples at posedge+1
  task automatic collect(input bit sel, input int budget);
    logic v, l, e;
    cn = 0; bub = 0; cto = 1;
    for (int c = 0; c < budget; c++) begin
      v = sel ? b_valid : a_valid;
      l = sel ? b_last  : a_last;
      e = sel ? b_empty : a_empty;
      if (v && out_ready) begin
        if (cn < 40) begin
          cv[cn] = sel ? b_value : a_value;
          ci[cn] = sel ? b_index : a_index;
          cl[cn] = l;
          ce[cn] = e;
        end
        cn++;
        if (l) begin cto = 0; break; end
      end else if (!v) bub++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({a_valid, a_last, a_empty, a_busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {a_valid, a_last, a_empty, a_busy});
    end
    vectors++;
    if ({a_value, a_index, a_nnz} !== 25'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {a_value, a_index, a_nnz});
    end
    rst_n = 1;
    @(posedge clk); #1;
    vectors++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", a_in_ready);
    end
  endtask

  task automatic test_basic;
    logic [511:0] f = '0;
    f[3*32 +: 32]  = 32'd5;
    f[7*32 +: 32]  = -32'sd4;
    f[12*32 +: 32] = 32'd65536;
    out_ready = 1;
    load(0, f);
    collect(0, 20);
    vectors++;
    if (cto || cn !== 2) begin
      errors++;
      $display("FAIL basic_count: got %0d beats expected 2", cn);
    end
    vectors++;
    if ({cv[0], ci[0], cl[0]} !== {16'd5, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_beat0: got %0d/%0d/%b expected 5/3/0",
               cv[0], ci[0], cl[0]);
    end
    vectors++;
    if ({cv[1], ci[1], cl[1]} !== {16'd32767, 4'd12, 1'b1}) begin
      errors++;
      $display("FAIL basic_beat1: got %0d/%0d/%b expected 32767/12/1",
               cv[1], ci[1], cl[1]);
    end
    @(posedge clk); #1;
    vectors++;
    if ({a_in_ready, a_valid, a_nnz} !== {1'b1, 1'b0, 5'd2}) begin
      errors++;
      $display("FAIL basic_after: got rdy %b vld %b nnz %0d expected 1 0 2",
               a_in_ready, a_valid, a_nnz);
    end
  endtask

  task automatic test_backpressure;
    logic [511:0] f = '0;
    f[3*32 +: 32]  = 32'd5;
    f[7*32 +: 32]  = -32'sd4;
    f[12*32 +: 32] = 32'd65536;
    out_ready = 0;
    load(0, f);
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({a_valid, a_value, a_index, a_last} !==
          {1'b1, 16'd5, 4'd3, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got %b/%0d/%0d/%b expected 1/5/3/0",
                 c, a_valid, a_value, a_index, a_last);
      end
      if (c < 2) begin @(posedge clk); #1; end
    end
    out_ready = 1;
    collect(0, 20);
    vectors++;
    if (cto || cn !== 2 || ci[0] !== 4'd3 || ci[1] !== 4'd12
        || cv[0] !== 16'd5 || cv[1] !== 16'd32767) begin
      errors++;
      $display("FAIL stall_seq: got n=%0d idx %0d,%0d expected n=2 idx 3,12",
               cn, ci[0], ci[1]);
    end
  endtask

  task automatic test_empty;
    logic [511:0] f;
    for (int t = 0; t < 2; t++) begin
      f = (t == 0) ? '0 : {16{32'hFFFF_FFF0}};
      out_ready = 1;
      load(0, f);
      collect(0, 10);
      vectors++;
      if (cto || cn !== 1 || {cv[0], ci[0], cl[0], ce[0]} !==
          {16'd0, 4'd0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL empty%0d: got n=%0d %0d/%0d/%b/%b expected 1 0/0/1/1",
                 t, cn, cv[0], ci[0], cl[0], ce[0]);
      end
      vectors++;
      if (a_nnz !== 5'd0) begin
        errors++;
        $display("FAIL empty_nnz%0d: got %0d expected 0", t, a_nnz);
      end
    end
  endtask

  task automatic test_all_ones;
    logic [511:0] f = {16{32'd1}};
    int bad = 0;
    out_ready = 1;
    load(0, f);
    vectors++;
    if (a_nnz !== 5'd16) begin
      errors++;
      $display("FAIL ones_nnz: got %0d expected 16", a_nnz);
    end
    collect(0, 40);
    vectors++;
    if (cto || cn !== 16 || bub !== 0) begin
      errors++;
      $display("FAIL ones_count: got n=%0d bubbles=%0d expected 16 0",
               cn, bub);
    end
    for (int i = 0; i < 16; i++) begin
      if (ci[i] !== 4'(i) || cv[i] !== 16'd1 || cl[i] !== (i == 15))
        bad++;
    end
    vectors++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ones_order: got %0d bad beats expected 0", bad);
    end
  endtask

  task automatic test_saturation;
    logic [511:0] f = '0;
    f[0*32 +: 32] = 32'd32767;
    f[1*32 +: 32] = 32'd32768;
    f[2*32 +: 32] = 32'h8000_0000;
    f[3*32 +: 32] = 32'd1;
    out_ready = 1;
    load(0, f);
    collect(0, 10);
    vectors++;
    if (cto || cn !== 3 || {cv[0], ci[0]} !== {16'd32767, 4'd0}
        || {cv[1], ci[1]} !== {16'd32767, 4'd1}
        || {cv[2], ci[2], cl[2]} !== {16'd1, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL sat_bounds: got n=%0d %0d@%0d %0d@%0d %0d@%0d",
               cn, cv[0], ci[0], cv[1], ci[1], cv[2], ci[2]);
    end
  endtask

  task automatic test_frac_shift;
    logic [511:0] f = '0;
    f[0*32 +: 32] = 32'd3;
    f[1*32 +: 32] = 32'd8;
    f[2*32 +: 32] = 32'd131072;
    out_ready = 1;
    load(1, f);
    collect(1, 10);
    vectors++;
    if (cto || cn !== 2) begin
      errors++;
      $display("FAIL frac_count: got %0d expected 2", cn);
    end
    vectors++;
    if ({cv[0], ci[0], cl[0], cv[1], ci[1], cl[1]} !==
        {16'd2, 4'd1, 1'b0, 16'd32767, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL frac_beats: got %0d/%0d/%b %0d/%0d/%b",
               cv[0], ci[0], cl[0], cv[1], ci[1], cl[1]);
    end
    vectors++;
    if (b_nnz !== 5'd2) begin
      errors++;
      $display("FAIL frac_nnz: got %0d expected 2", b_nnz);
    end
  endtask

  task automatic test_reset_mid;
    logic [511:0] f = '0;
    logic [511:0] g = '0;
    f[2*32 +: 32]  = 32'd7;
    f[5*32 +: 32]  = 32'd9;
    f[9*32 +: 32]  = 32'd11;
    g[1*32 +: 32]  = 32'd100;
    g[14*32 +: 32] = 32'd200;
    out_ready = 1;
    load(0, f);
    @(posedge clk); #1;
    vectors++;
    if ({a_valid, a_value, a_index} !== {1'b1, 16'd9, 4'd5}) begin
      errors++;
      $display("FAIL rst_pre: got %b/%0d/%0d expected 1/9/5",
               a_valid, a_value, a_index);
    end
    #1 rst_n = 0;
    #1;
    vectors++;
    if ({a_valid, a_busy, a_nnz} !== {1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL rst_async: got vld %b busy %b nnz %0d expected 0 0 0",
               a_valid, a_busy, a_nnz);
    end
    @(posedge clk); #1;
    rst_n = 1;
    load(0, g);
    collect(0, 10);
    vectors++;
    if (cto || cn !== 2 || {cv[0], ci[0], cl[0]} !==
        {16'd100, 4'd1, 1'b0} || {cv[1], ci[1], cl[1]} !==
        {16'd200, 4'd14, 1'b1}) begin
      errors++;
      $display("FAIL rst_next: got n=%0d %0d@%0d %0d@%0d",
               cn, cv[0], ci[0], cv[1], ci[1]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_all_ones();
    test_saturation();
    test_frac_shift();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
